// File: rtl/ula_pkg.sv
// ula_pkg: shared op encodings, multdiv FSM states and ALU control codes
package ula_pkg;
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;
  typedef enum logic [1:0] {IDLE, CALC, AJUSTE} state_t;
  typedef enum logic [3:0] {
    CTL_ADD  = 4'b0000,
    CTL_SUB  = 4'b0001,
    CTL_AND  = 4'b0010,
    CTL_OR   = 4'b0011,
    CTL_XOR  = 4'b0100,
    CTL_NOR  = 4'b0101,
    CTL_SLT  = 4'b0110,
    CTL_SLTU = 4'b0111,
    CTL_SLL  = 4'b1000,
    CTL_SRL  = 4'b1001,
    CTL_SRA  = 4'b1010,
    CTL_LUI  = 4'b1011,
    CTL_EQ   = 4'b1100,
    CTL_NE   = 4'b1101
  } controle_t;
endpackage

// File: rtl/ula_multdiv_iter.sv
// ula_multdiv_iter: one shift-add multiply step or one restoring divide step
module ula_multdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   acc_next
);
  logic [WIDTH:0] sum, diff;
  // multiply keeps the add carry as the new top bit; divide trial-subtracts the shifted remainder
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : '0);
    diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b};
    acc_next = !div ? {sum, acc[WIDTH-1:1]} :
               diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} :
               {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end
endmodule

// File: rtl/ula_multdiv.sv
// ula_multdiv: multi-cycle multiply/divide unit owning the HI/LO registers
module ula_multdiv import ula_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  input  logic                 wr_hi,
  input  logic                 wr_lo,
  input  logic [WIDTH-1:0]     wdata,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     hi,
  output logic [WIDTH-1:0]     lo,
  output logic [2*WIDTH-1:0]   out_64,
  output logic                 sign_hilo
);
  localparam int CW = $clog2(WIDTH);
  state_t               state;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc, acc_next, res;
  logic [WIDTH-1:0]     b_r, a_r, mag1, mag2, rem, quo;
  logic                 is_div, is_signed, neg_a, neg_x, div0, s1, s2;
  ula_multdiv_iter #(.WIDTH(WIDTH)) u_iter (
    .div(is_div),
    .acc(acc),
    .b(b_r),
    .acc_next(acc_next)
  );
  // operand magnitudes at accept time and the sign-corrected result at fix-up time
  always_comb begin
    s1 = !op[0] && in1[WIDTH-1];
    s2 = !op[0] && in2[WIDTH-1];
    mag1 = s1 ? -in1 : in1;
    mag2 = s2 ? -in2 : in2;
    rem = acc[2*WIDTH-1:WIDTH];
    quo = acc[WIDTH-1:0];
    res = !is_div ? (neg_x ? -acc : acc) :
          div0 ? {a_r, {WIDTH{1'b0}}} :
          {neg_a ? -rem : rem, neg_x ? -quo : quo};
  end
  assign busy = state != IDLE;
  assign out_64 = {hi, lo};
  // control FSM: accept, iterate WIDTH times, then write HI/LO and pulse done
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      b_r <= '0;
      a_r <= '0;
      is_div <= 1'b0;
      is_signed <= 1'b0;
      neg_a <= 1'b0;
      neg_x <= 1'b0;
      div0 <= 1'b0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
      sign_hilo <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc <= {{WIDTH{1'b0}}, op[1] ? mag1 : mag2};
            b_r <= op[1] ? mag2 : mag1;
            a_r <= in1;
            is_div <= op[1];
            is_signed <= !op[0];
            neg_a <= s1;
            neg_x <= s1 ^ s2;
            div0 <= in2 == '0;
            cnt <= CW'(WIDTH - 1);
            state <= CALC;
          end else begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= AJUSTE;
        end
        AJUSTE: begin
          {hi, lo} <= res;
          sign_hilo <= is_signed;
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ula_multdiv.sv
// tb_ula_multdiv: directed and random checks of ula_multdiv against an arithmetic model
module tb_ula_multdiv;
  logic        clock = 0, reset = 1, start = 0, wr_hi = 0, wr_lo = 0;
  logic [1:0]  op = 0;
  logic [31:0] in1 = 0, in2 = 0, wdata = 0;
  logic        busy, done, sign_hilo;
  logic [31:0] hi, lo;
  logic [63:0] out_64;
  int tests = 0, fails = 0;

  ula_multdiv #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .in1(in1), .in2(in2),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .out_64(out_64), .sign_hilo(sign_hilo)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (o == 2'd0) return 64'(sa * sb);
    if (o == 2'd1) return ua * ub;
    if (b == 0) return {a, 32'b0};
    if (o == 2'd2) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {32'(ua % ub), 32'(ua / ub)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  task automatic check_result(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    e = model(o, a, b);
    chk({tag, " hi"}, 64'(hi), 64'(e[63:32]));
    chk({tag, " lo"}, 64'(lo), 64'(e[31:0]));
    chk({tag, " out_64"}, out_64, e);
    chk({tag, " sign_hilo"}, 64'(sign_hilo), 64'(!o[0]));
    chk({tag, " busy in done cycle"}, 64'(busy), 64'(0));
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clock);
    op = o; in1 = a; in2 = b; start = 1;
    @(posedge clock);
    #1;
    start = 0;
    chk({tag, " busy after accept"}, 64'(busy), 64'(1));
    wait_done(n);
    chk({tag, " latency"}, 64'(n), 64'(33));
    check_result(tag, o, a, b);
    @(posedge clock);
    #1;
    chk({tag, " done one cycle"}, 64'(done), 64'(0));
  endtask

  initial begin
    int n, pulses;
    logic [31:0] h0;
    logic [1:0] ro;
    logic [31:0] ra, rb;
    repeat (3) @(posedge clock);
    #1;
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset hilo", out_64, 64'(0));
    chk("reset sign", 64'(sign_hilo), 64'(0));
    @(negedge clock);
    reset = 0;

    run_op("multu max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu max const", out_64, 64'hFFFF_FFFE_0000_0001);
    run_op("mult -7*3", 2'd0, -32'sd7, 32'd3);
    chk("mult -7*3 const", out_64, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("div -7/2", 2'd2, -32'sd7, 32'd2);
    chk("div -7/2 const", out_64, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu 100/0", 2'd3, 32'd100, 32'd0);
    chk("divu by zero const", out_64, {32'd100, 32'd0});
    run_op("div ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div ovf const", out_64, {32'd0, 32'h8000_0000});
    run_op("div -9/0", 2'd2, -32'sd9, 32'd0);

    // start and mthi while busy are ignored
    @(negedge clock);
    op = 2'd1; in1 = 32'd1000; in2 = 32'd3; start = 1;
    @(posedge clock);
    #1;
    start = 0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    op = 2'd3; in1 = 32'd77; in2 = 32'd5; start = 1; wr_hi = 1; wdata = 32'h1234;
    @(posedge clock);
    #1;
    start = 0; wr_hi = 0;
    wait_done(n);
    chk("busy-ignore latency", 64'(n + 5), 64'(33));
    check_result("busy-ignore", 2'd1, 32'd1000, 32'd3);
    @(posedge clock);
    #1;
    chk("busy-ignore no second op", 64'(busy), 64'(0));

    // mthi / mtlo in idle
    @(negedge clock);
    wr_hi = 1; wdata = 32'h1234;
    @(posedge clock);
    #1;
    wr_hi = 0;
    chk("mthi hi", 64'(hi), 64'h1234);
    chk("mthi lo kept", 64'(lo), 64'd3000);
    chk("mthi sign kept", 64'(sign_hilo), 64'(0));
    @(negedge clock);
    wr_lo = 1; wdata = 32'hCAFE_F00D;
    @(posedge clock);
    #1;
    wr_lo = 0;
    chk("mtlo", out_64, {32'h1234, 32'hCAFE_F00D});

    // reset in the middle of a DIVU
    @(negedge clock);
    op = 2'd3; in1 = 32'd12345; in2 = 32'd7; start = 1;
    @(posedge clock);
    #1;
    start = 0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1;
    #1;
    chk("midreset busy", 64'(busy), 64'(0));
    chk("midreset hilo", out_64, 64'(0));
    chk("midreset done", 64'(done), 64'(0));
    @(negedge clock);
    reset = 0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (done) pulses++;
    end
    chk("midreset no done", 64'(pulses), 64'(0));
    run_op("after reset", 2'd3, 32'd12345, 32'd7);

    // back-to-back with start held across the done cycle
    @(negedge clock);
    op = 2'd0; in1 = 32'hFFFF_0001; in2 = 32'h0000_7FFF; start = 1;
    @(posedge clock);
    #1;
    wait_done(n);
    chk("b2b first latency", 64'(n), 64'(33));
    check_result("b2b first", 2'd0, 32'hFFFF_0001, 32'h0000_7FFF);
    op = 2'd2; in1 = 32'd1000001; in2 = -32'sd13;
    @(posedge clock);
    #1;
    start = 0;
    chk("b2b second accepted", 64'(busy), 64'(1));
    h0 = hi;
    chk("b2b hi holds", 64'(h0), 64'(model(2'd0, 32'hFFFF_0001, 32'h0000_7FFF) >> 32));
    wait_done(n);
    chk("b2b spacing", 64'(n + 1), 64'(34));
    check_result("b2b second", 2'd2, 32'd1000001, -32'sd13);

    // random ops against the model
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 1000)));
      if (ro[1] && $urandom_range(0, 1)) rb = -rb;
      run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ula_multdiv.md
# ula_multdiv

Multi-cycle multiply/divide unit that produces the 64-bit HI/LO result the single-cycle ALU reserves but always drives to zero (`out_64`, `sign_hilo`). It accepts an operation from the execute stage and iterates one bit per cycle (shift-add for multiply, restoring for divide). It holds the result in architectural HI/LO registers that the datapath reads for mfhi/mflo and writes for mthi/mtlo.

## Interface
- `WIDTH`, 32, operand width; HI, LO and the 64-bit result are WIDTH / 2*WIDTH.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: request, sampled on the rising edge.
- `op` in 2: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `in1` in WIDTH: multiplicand / dividend.
- `in2` in WIDTH: multiplier / divisor.
- `wr_hi`, `wr_lo` in 1: mthi/mtlo write enables.
- `wdata` in WIDTH: mthi/mtlo data.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse when HI/LO is updated by an operation.
- `hi`, `lo` out WIDTH: HI/LO registers.
- `out_64` out 2*WIDTH: {hi, lo}.
- `sign_hilo` out 1: the last completed operation was signed (MULT/DIV).

## Operation
- States:
  - IDLE: waits for a request.
  - CALC: WIDTH iterations, one per cycle.
  - AJUSTE: sign fix-up and result write.
- IDLE, `start`=1: latch op and operands.
  - Signed ops convert operands to magnitudes and record the result signs.
  - Set the iteration counter to WIDTH-1; go to CALC.
- CALC, multiply: if the multiplier LSB is 1, add the multiplicand to the upper accumulator half; shift the accumulator right 1.
- CALC, divide: shift {remainder, quotient} left 1; trial-subtract the divisor; keep the difference and set the quotient bit if it is non-negative.
- CALC ends after the iteration with counter 0, then goes to AJUSTE.
- AJUSTE:
  - Apply signs: a negative product is negated as 2*WIDTH bits; the quotient takes sign(in1) xor sign(in2); the remainder takes sign(in1).
  - Write HI/LO: multiply gives hi=product[2W-1:W], lo=product[W-1:0]; divide gives hi=remainder, lo=quotient.
  - Set `sign_hilo` = op[0]==0; pulse `done`; go to IDLE.
- Division by zero: still takes full latency; result hi=in1 (original), lo=0.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- `start` while busy: ignored and not queued.
- `wr_hi`/`wr_lo` in IDLE with `start`=0: write `wdata` on the edge; `sign_hilo` is unchanged.
- `wr_hi`/`wr_lo` while busy, or in the same cycle as an accepted `start`: dropped.
- Reset, including mid-operation: state IDLE, hi=lo=0, busy=0, done=0, sign_hilo=0, counter=0. The in-flight result is discarded.

## Timing
- The accepting edge is E0.
- `busy` = (state != IDLE): high from after E0 through the AJUSTE cycle.
- HI/LO update and `done` rise on edge E0+WIDTH+1; `done` is high for exactly one cycle, and `busy` is low in that cycle.
- Fixed latency for every op, including division by zero: result is visible WIDTH+1 edges after acceptance (33 for WIDTH=32).
- A new `start` in the `done` cycle is accepted, so back-to-back ops run every WIDTH+2 cycles.
- `hi`, `lo`, `out_64` are direct register outputs, stable between updates.
- mthi/mtlo are visible the cycle after the write edge.

## Structure
- Package `ula_pkg`:
  - op encodings `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`;
  - state typedef (IDLE/CALC/AJUSTE);
  - the ALU `controle` codes (0000 add … 1101 ne), so decode logic has a single source.
- One sub-module: `ula_multdiv_iter`, the combinational single-iteration datapath (multiply step / divide step). The parent owns the FSM, counter, sign handling and HI/LO.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → 33 edges later: hi=0xFFFFFFFE, lo=0x00000001, done pulse, sign_hilo=0.
- MULT (-7) × 3 → hi=0xFFFFFFFF, lo=0xFFFFFFEB, sign_hilo=1; DIV (-7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 → full latency, hi=100, lo=0; DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- `start` pulsed while busy, and `wr_hi`=1 with wdata=0x1234 while busy → ignored; hi/lo hold the first op's result only; mthi 0x1234 in IDLE → hi=0x1234 next cycle.
- Reset asserted at cycle 10 of a DIVU → immediately busy=0, hi=lo=0, no done pulse; the next start completes normally.
- Back-to-back: start held across the done cycle → second op accepted on that edge; second done exactly 34 cycles after the first.
